// File: rtl/alu_16_seq_if.sv
// alu_16_seq_if: command/result valid-ready bundle for alu_16_seq
// Command side: in_valid/in_ready handshake carrying in_a, in_b, in_ctrl, in_tag.
// Result side: out_valid/out_ready handshake carrying out_s, out_zero, out_ovf, out_illegal, out_tag.
// master = command source / result consumer, slave = alu_16_seq.
interface alu_16_seq_if #(parameter int TAG_W = 4);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic [3:0]       in_ctrl;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_s;
    logic             out_zero;
    logic             out_ovf;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;
    modport master (
        output in_valid, in_a, in_b, in_ctrl, in_tag, out_ready,
        input  in_ready, out_valid, out_s, out_zero, out_ovf, out_illegal, out_tag
    );
    modport slave (
        input  in_valid, in_a, in_b, in_ctrl, in_tag, out_ready,
        output in_ready, out_valid, out_s, out_zero, out_ovf, out_illegal, out_tag
    );
endinterface

// File: rtl/alu_16_seq.sv
// alu_16_seq: registered valid/ready front-end around the combinational alu_16
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   bus (slave)           command channel in -> result channel out (see alu_16_seq_if)
//   stat_clr              synchronous clear of both statistics counters
//   ops_count, ovf_count  saturating counts of retired results / retired overflows
// alu_16: combinational 16-bit ALU (a, b, ctrl -> s, zero, overflow); shifts move A by one bit.
module alu_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  ctrl,
    output logic [15:0] s,
    output logic        zero,
    output logic        overflow
);
    always_comb begin
        s = '0;
        overflow = 1'b0;
        case (ctrl)
            4'b0000: begin
                s = a - b;
                overflow = (a[15] != b[15]) && (s[15] != a[15]);
            end
            4'b0001: begin
                s = a + b;
                overflow = (a[15] == b[15]) && (s[15] != a[15]);
            end
            4'b0010: s = a | b;
            4'b0011: s = a & b;
            4'b0100: begin
                s = a - 16'd1;
                overflow = a == 16'h8000;
            end
            4'b0101: begin
                s = a + 16'd1;
                overflow = a == 16'h7FFF;
            end
            4'b0110: s = ~a;
            4'b1000: s = {a[14:0], 1'b0};
            4'b1001: s = {15'd0, $signed(a) <= $signed(b)};
            4'b1010: s = {1'b0, a[15:1]};
            4'b1100: begin
                s = {a[14:0], 1'b0};
                overflow = a[15] ^ a[14];
            end
            4'b1110: s = {a[15], a[15:1]};
            default: s = '0;
        endcase
    end
    assign zero = s == 16'd0;
endmodule

module alu_16_seq #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_16_seq_if.slave      bus,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] ops_count,
    output logic [CNT_W-1:0] ovf_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [1:0]       state;
    logic [15:0]      a_r;
    logic [15:0]      b_r;
    logic [3:0]       ctrl_r;
    logic [TAG_W-1:0] tag_r;
    logic [15:0]      alu_s;
    logic             alu_zero;
    logic             alu_ovf;
    logic             illegal;
    logic             accept;
    logic             retire;
    logic [15:0]      s_r;
    logic             zero_r;
    logic             ovf_r;
    logic             ill_r;
    logic [TAG_W-1:0] otag_r;
    assign retire        = state == DONE && bus.out_ready;
    // a retiring result frees the slot in the same cycle, allowing back-to-back commands
    assign bus.in_ready  = state == IDLE || retire;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = state == DONE;
    // illegal codes 0111/1011/1101/1111: odd codes with two or more of the upper bits set
    assign illegal = ctrl_r[0] & ((ctrl_r[3] & ctrl_r[2]) | (ctrl_r[3] & ctrl_r[1]) | (ctrl_r[2] & ctrl_r[1]));
    alu_16 u_alu (
        .a(a_r),
        .b(b_r),
        .ctrl(ctrl_r),
        .s(alu_s),
        .zero(alu_zero),
        .overflow(alu_ovf)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            ctrl_r    <= '0;
            tag_r     <= '0;
            s_r       <= '0;
            zero_r    <= 1'b0;
            ovf_r     <= 1'b0;
            ill_r     <= 1'b0;
            otag_r    <= '0;
            ops_count <= '0;
            ovf_count <= '0;
        end else begin
            state <= accept ? EXEC : state == EXEC ? DONE : (state == DONE && !bus.out_ready) ? DONE : IDLE;
            if (accept) begin
                a_r    <= bus.in_a;
                b_r    <= bus.in_b;
                ctrl_r <= bus.in_ctrl;
                tag_r  <= bus.in_tag;
            end
            if (state == EXEC) begin
                s_r    <= illegal ? 16'd0 : alu_s;
                zero_r <= !illegal && alu_zero;
                ovf_r  <= !illegal && alu_ovf;
                ill_r  <= illegal;
                otag_r <= tag_r;
            end
            ops_count <= stat_clr ? '0 : (retire && ops_count != CNT_MAX) ? ops_count + 1'b1 : ops_count;
            ovf_count <= stat_clr ? '0 : (retire && ovf_r && ovf_count != CNT_MAX) ? ovf_count + 1'b1 : ovf_count;
        end
    end
    assign bus.out_s       = s_r;
    assign bus.out_zero    = zero_r;
    assign bus.out_ovf     = ovf_r;
    assign bus.out_illegal = ill_r;
    assign bus.out_tag     = otag_r;
endmodule
